counter64_reader: RTL and testbench

Read-side companion of the 32-bit free-running `counter`. It consumes the counter's `count`/`ovf` outputs and extends them to a coherent 64-bit timestamp by counting overflow pulses into a high word. It captures snapshots on request and computes the elapsed time between consecutive snapshots. It exposes everything through a simple 32-bit register read port that feeds the AXI-lite slave wrapper of the counter64 IP used for Hotspot2D kernel timing.

---
 rtl/counter64_reader.sv | 224 ++++++++++++++++++++++
 tb/tb_counter64_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter64_reader.sv
// ---------------------------------------------------------------------------
// counter64_reader
//
// Read-side companion of the 32-bit free-running `counter`. Extends the
// counter's low word to a coherent 64-bit timestamp by counting overflow
// pulses into a high word. Captures snapshots on request, computes the
// elapsed time between consecutive snapshots, and exposes everything
// through a small 32-bit register read port.
//
// Parameters:
//   HI_W     width of the overflow-extension (high) word; 32 for a full
//            64-bit timestamp. Must be in 1..32. Narrower values only
//            shorten the high word; the snapshot/delta path stays 64 bits.
//
// Ports:
//   clk      in   1   clock, shared with the `counter` instance
//   res      in   1   asynchronous active-high reset
//   clr      in   1   synchronous clear of all timestamp state
//   cnt_lo   in  32   `count` output of `counter`
//   cnt_ovf  in   1   `ovf` output of `counter` (high while cnt_lo reads 0
//                     right after a wrap)
//   snap     in   1   capture request, one-cycle pulse
//   rd_en    in   1   read strobe
//   rd_addr  in   3   read register index
//   rd_valid out  1   read data valid
//   rd_data  out 32   read data
//
// Register map (rd_addr):
//   0  live[31:0]   (also latches live[63:32] into shadow_hi)
//   1  shadow_hi
//   2  snap_val[31:0]
//   3  snap_val[63:32]
//   4  delta[31:0]
//   5  delta[63:32]
//   6  status {snap_cnt[15:0], 14'b0, delta_valid, hi_wrap}; clears hi_wrap
//   7  zero
// ---------------------------------------------------------------------------
module counter64_reader #(
  parameter int HI_W = 32
) (
  input  logic        clk,
  input  logic        res,
  input  logic        clr,
  input  logic [31:0] cnt_lo,
  input  logic        cnt_ovf,
  input  logic        snap,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic        rd_valid,
  output logic [31:0] rd_data
);

  localparam logic [2:0] ADDR_LIVE_LO = 3'd0;
  localparam logic [2:0] ADDR_SHADOW  = 3'd1;
  localparam logic [2:0] ADDR_SNAP_LO = 3'd2;
  localparam logic [2:0] ADDR_SNAP_HI = 3'd3;
  localparam logic [2:0] ADDR_DELT_LO = 3'd4;
  localparam logic [2:0] ADDR_DELT_HI = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [HI_W-1:0] hi_cnt;
  logic            hi_wrap;
  logic [31:0]     shadow_hi;
  logic [63:0]     snap_val;
  logic [63:0]     prev_val;
  logic [15:0]     snap_cnt;
  logic            d_pend;
  logic [63:0]     delta;
  logic            delta_valid;

  // -------------------------------------------------------------------------
  // Coherent live value
  // -------------------------------------------------------------------------
  // In the cnt_ovf cycle the low word already reads 0 while hi_cnt only
  // increments on the closing edge, so the pending carry is folded in here.
  // Without it a read in that cycle would return {old_hi, 0}, a value that
  // lies behind time.
  logic [HI_W-1:0] hi_live;
  logic [63:0]     live;

  assign hi_live = hi_cnt + HI_W'(cnt_ovf);
  assign live    = (64'(hi_live) << 32) | 64'(cnt_lo);

  // -------------------------------------------------------------------------
  // Decoded strobes
  // -------------------------------------------------------------------------
  logic        wrap_set;
  logic        stat_rd;
  logic        live_rd;
  logic [15:0] snap_cnt_nxt;

  assign wrap_set     = cnt_ovf & (&hi_cnt);
  assign stat_rd      = rd_en & (rd_addr == ADDR_STATUS);
  assign live_rd      = rd_en & (rd_addr == ADDR_LIVE_LO);
  // Snapshot count saturates rather than wrapping so software can tell
  // "many" from "few".
  assign snap_cnt_nxt = (&snap_cnt) ? snap_cnt : snap_cnt + 16'd1;

  // -------------------------------------------------------------------------
  // Overflow extension and sticky wrap flag
  // -------------------------------------------------------------------------
  // A wrap in the same cycle as a status read keeps the flag set: the read
  // returned the pre-edge value (0), so clearing would lose the event.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hi_cnt  <= '0;
      hi_wrap <= 1'b0;
    end else if (clr) begin
      hi_cnt  <= '0;
      hi_wrap <= 1'b0;
    end else begin
      if (cnt_ovf) begin
        hi_cnt <= hi_live;
      end
      if (wrap_set) begin
        hi_wrap <= 1'b1;
      end else if (stat_rd) begin
        hi_wrap <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shadow of the live high word, latched by a low-word read so that a
  // following read of address 1 pairs with the low word already returned.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      shadow_hi <= '0;
    end else if (clr) begin
      shadow_hi <= '0;
    end else if (live_rd) begin
      shadow_hi <= 32'(hi_live);
    end
  end

  // -------------------------------------------------------------------------
  // Snapshot stage
  // -------------------------------------------------------------------------
  // d_pend marks that the capture just taken has a predecessor; it is a
  // one-cycle token consumed by the delta stage on the next edge. The very
  // first capture after reset/clear therefore never produces a delta.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      snap_val <= '0;
      prev_val <= '0;
      snap_cnt <= '0;
      d_pend   <= 1'b0;
    end else if (clr) begin
      snap_val <= '0;
      prev_val <= '0;
      snap_cnt <= '0;
      d_pend   <= 1'b0;
    end else begin
      d_pend <= 1'b0;
      if (snap) begin
        snap_val <= live;
        prev_val <= snap_val;
        snap_cnt <= snap_cnt_nxt;
        d_pend   <= (snap_cnt != 16'd0);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Delta stage
  // -------------------------------------------------------------------------
  // Runs one cycle behind the snapshot stage. With back-to-back snaps the
  // snapshot stage has already moved on, but snap_val/prev_val in this cycle
  // are still exactly the pair that raised d_pend, so each delta belongs to
  // its own adjacent pair. Subtraction is modulo 2^64.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      delta       <= '0;
      delta_valid <= 1'b0;
    end else if (clr) begin
      delta       <= '0;
      delta_valid <= 1'b0;
    end else if (d_pend) begin
      delta       <= snap_val - prev_val;
      delta_valid <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Read port
  // -------------------------------------------------------------------------
  // Handshake: rd_en is a single-cycle request with no backpressure; every
  // cycle with rd_en=1 produces exactly one cycle of rd_valid=1 on the next
  // clock, carrying the register contents as they stood in the rd_en cycle.
  // rd_data is only meaningful while rd_valid=1 and otherwise holds its last
  // value. clr does not touch the read port.
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = 32'h0;
    unique case (rd_addr)
      ADDR_LIVE_LO: rd_mux = cnt_lo;
      ADDR_SHADOW:  rd_mux = shadow_hi;
      ADDR_SNAP_LO: rd_mux = snap_val[31:0];
      ADDR_SNAP_HI: rd_mux = snap_val[63:32];
      ADDR_DELT_LO: rd_mux = delta[31:0];
      ADDR_DELT_HI: rd_mux = delta[63:32];
      ADDR_STATUS:  rd_mux = {snap_cnt, 14'b0, delta_valid, hi_wrap};
      default:      rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_counter64_reader.sv
// ---------------------------------------------------------------------------
// tb_counter64_reader
//
// Bench for counter64_reader. The main instance (HI_W=32) is driven one
// cycle at a time through step(); a behavioural model of the timestamp
// (overflow count, list of snapshot values, deltas landing two cycles after
// their snap) produces the expected read data, which is queued and checked
// by an independent monitor whenever rd_valid is seen. A second instance
// with a 2-bit high word reaches the high-word wrap in a few cycles.
// ---------------------------------------------------------------------------
module tb_counter64_reader;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res;
  logic        clr;
  logic [31:0] cnt_lo;
  logic        cnt_ovf;
  logic        snap;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;

  logic        w_clr;
  logic        w_ovf;
  logic        w_rd_en;
  logic [2:0]  w_addr;
  logic        w_valid;
  logic [31:0] w_data;

  counter64_reader dut (
    .clk      (clk),
    .res      (res),
    .clr      (clr),
    .cnt_lo   (cnt_lo),
    .cnt_ovf  (cnt_ovf),
    .snap     (snap),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  counter64_reader #(.HI_W(2)) dut_w (
    .clk      (clk),
    .res      (res),
    .clr      (w_clr),
    .cnt_lo   (32'd0),
    .cnt_ovf  (w_ovf),
    .snap     (1'b0),
    .rd_en    (w_rd_en),
    .rd_addr  (w_addr),
    .rd_valid (w_valid),
    .rd_data  (w_data)
  );

  int checks = 0;
  int errors = 0;

  // -------------------------------------------------------------------------
  // Reference model (main instance)
  // -------------------------------------------------------------------------
  logic [31:0] m_hi;
  bit          m_wrap;
  logic [31:0] m_shadow;
  logic [63:0] m_snap;
  logic [63:0] m_delta;
  bit          m_dvalid;
  int          m_snap_cnt;
  int          due_q[$];
  logic [63:0] dval_q[$];
  int          cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] w_exp_q[$];

  task automatic model_clear();
    m_hi       = 32'h0;
    m_wrap     = 1'b0;
    m_shadow   = 32'h0;
    m_snap     = 64'h0;
    m_delta    = 64'h0;
    m_dvalid   = 1'b0;
    m_snap_cnt = 0;
    due_q.delete();
    dval_q.delete();
  endtask

  function automatic logic [31:0] reg_val(input logic [2:0] a, input logic [63:0] live);
    case (a)
      3'd0:    return live[31:0];
      3'd1:    return m_shadow;
      3'd2:    return m_snap[31:0];
      3'd3:    return m_snap[63:32];
      3'd4:    return m_delta[31:0];
      3'd5:    return m_delta[63:32];
      3'd6:    return {16'(m_snap_cnt), 14'b0, m_dvalid, m_wrap};
      default: return 32'h0;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Driver: one clock cycle of stimulus on the main instance
  // -------------------------------------------------------------------------
  task automatic step(input logic [31:0] lo, input bit ovf, input bit sn,
                      input bit re, input logic [2:0] a, input bit cl);
    logic [31:0] live_hi;
    logic [63:0] live;
    @(posedge clk);
    #1;
    cnt_lo  = lo;
    cnt_ovf = ovf;
    snap    = sn;
    rd_en   = re;
    rd_addr = a;
    clr     = cl;
    cyc++;
    // deltas whose snap was two or more cycles ago are visible now
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      m_delta  = dval_q.pop_front();
      m_dvalid = 1'b1;
    end
    live_hi = m_hi + 32'(ovf);
    live    = {live_hi, lo};
    if (re) exp_q.push_back(reg_val(a, live));
    // state as it stands after this cycle's closing edge
    if (cl) begin
      model_clear();
    end else begin
      if (re && a == 3'd0) m_shadow = live_hi;
      if (sn) begin
        if (m_snap_cnt != 0) begin
          due_q.push_back(cyc + 2);
          dval_q.push_back(live - m_snap);
        end
        m_snap = live;
        if (m_snap_cnt < 65535) m_snap_cnt++;
      end
      if (ovf && m_hi == 32'hFFFF_FFFF) m_wrap = 1'b1;
      else if (re && a == 3'd6)         m_wrap = 1'b0;
      m_hi = m_hi + 32'(ovf);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(cnt_lo, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] lo, input logic [2:0] a);
    step(lo, 1'b0, 1'b0, 1'b1, a, 1'b0);
  endtask

  // Driver for the narrow instance; expected values are fixed constants.
  task automatic wstep(input bit ovf, input bit re, input logic [2:0] a,
                       input bit cl, input logic [31:0] e);
    @(posedge clk);
    #1;
    w_ovf   = ovf;
    w_rd_en = re;
    w_addr  = a;
    w_clr   = cl;
    if (re) w_exp_q.push_back(e);
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard monitors
  // -------------------------------------------------------------------------
  logic [31:0] last_exp;

  always @(negedge clk) begin
    if (res) begin
      last_exp = 32'h0;
    end else if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 data=%h with nothing expected", rd_data);
      end else begin
        last_exp = exp_q.pop_front();
        if (rd_data !== last_exp) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h (t=%0t)", rd_data, last_exp, $time);
        end
      end
    end else begin
      checks++;
      if (rd_data !== last_exp) begin
        errors++;
        $display("FAIL rd_hold: got %h expected %h (t=%0t)", rd_data, last_exp, $time);
      end
    end
  end

  always @(negedge clk) begin
    if (!res && w_valid) begin
      checks++;
      if (w_exp_q.size() == 0) begin
        errors++;
        $display("FAIL w_unexpected: rd_valid=1 data=%h with nothing expected", w_data);
      end else begin
        logic [31:0] e;
        e = w_exp_q.pop_front();
        if (w_data !== e) begin
          errors++;
          $display("FAIL w_rd_data: got %h expected %h (t=%0t)", w_data, e, $time);
        end
      end
    end
  end

  task automatic check_direct(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] lo;
    bit          ovf;

    res = 1'b1; clr = 1'b0; cnt_lo = 32'h0; cnt_ovf = 1'b0; snap = 1'b0;
    rd_en = 1'b0; rd_addr = 3'd0;
    w_clr = 1'b0; w_ovf = 1'b0; w_rd_en = 1'b0; w_addr = 3'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    check_direct("reset_rd_valid", 32'(rd_valid), 32'h0);
    check_direct("reset_rd_data", rd_data, 32'h0);
    res = 1'b0;

    // ---- high-word wrap on the narrow instance ----
    for (int i = 0; i < 3; i++) wstep(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
    wstep(1'b1, 1'b1, 3'd6, 1'b0, 32'h0);  // wrap edge vs status read
    wstep(1'b0, 1'b1, 3'd6, 1'b0, 32'h1);  // set beat the clear
    wstep(1'b0, 1'b1, 3'd6, 1'b0, 32'h0);  // cleared by previous read
    wstep(1'b1, 1'b1, 3'd0, 1'b0, 32'h0);  // shadow gets hi+carry = 1
    wstep(1'b0, 1'b1, 3'd1, 1'b0, 32'h1);
    for (int i = 0; i < 3; i++) wstep(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
    wstep(1'b0, 1'b1, 3'd6, 1'b1, 32'h1);  // clr does not alter the read
    wstep(1'b0, 1'b1, 3'd6, 1'b0, 32'h0);
    wstep(1'b0, 1'b1, 3'd1, 1'b0, 32'h0);
    wstep(1'b0, 1'b0, 3'd0, 1'b0, 32'h0);

    // ---- wrap coherence of the live value ----
    idle(1);
    rd(32'hFFFF_FFFE, 3'd0);
    rd(32'hFFFF_FFFE, 3'd1);
    rd(32'hFFFF_FFFF, 3'd0);
    rd(32'hFFFF_FFFF, 3'd1);
    step(32'h0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
    rd(32'h1, 3'd1);

    // ---- simple delta ----
    step(32'd5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(32'd100, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    rd(32'd101, 3'd2);
    idle(2);
    rd(32'd104, 3'd6);
    step(32'd1100, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    rd(32'd1101, 3'd4);  // one cycle after: not yet visible
    rd(32'd1102, 3'd4);
    rd(32'd1103, 3'd5);
    rd(32'd1104, 3'd6);

    // ---- delta across an overflow ----
    step(32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(32'hFFFF_FF00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    step(32'h100, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    idle(1);
    rd(32'h102, 3'd4);
    rd(32'h103, 3'd5);
    rd(32'h104, 3'd3);

    // ---- back-to-back snaps with continuous reads ----
    step(32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(32'd500, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
    step(32'd501, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
    step(32'd502, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
    rd(32'd503, 3'd4);
    rd(32'd504, 3'd4);
    rd(32'd505, 3'd6);

    // ---- clr against ovf, snap and status read in the same cycle ----
    step(32'd10, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    step(32'd20, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(32'h0, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1);
    for (int a = 1; a < 8; a++) rd(32'd7, 3'(a));
    rd(32'd8, 3'd0);
    rd(32'd8, 3'd1);

    // ---- async reset mid-operation with hi=5 and a delta in flight ----
    step(32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 5; i++) step(32'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    rd(32'd3, 3'd0);
    rd(32'd4, 3'd1);
    step(32'd50, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(32'd60, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0);
    @(posedge clk);
    #2;
    res = 1'b1;
    snap = 1'b0; rd_en = 1'b0; cnt_ovf = 1'b0;
    #1;
    check_direct("async_rd_valid", 32'(rd_valid), 32'h0);
    check_direct("async_rd_data", rd_data, 32'h0);
    model_clear();
    exp_q.delete();
    @(posedge clk);
    #3;
    res = 1'b0;
    idle(2);
    rd(32'd70, 3'd6);
    rd(32'd71, 3'd4);
    rd(32'd72, 3'd1);
    rd(32'd73, 3'd3);

    // ---- randomized traffic ----
    lo = 32'd1000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) lo = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      lo  = lo + 32'd1;
      ovf = (lo == 32'h0);
      step(lo, ovf, ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 70),
           3'($urandom_range(0, 7)), ($urandom_range(0, 79) == 0));
    end

    idle(4);
    @(negedge clk);
    #1;
    check_direct("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check_direct("w_exp_q_drained", 32'(w_exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
